// File: rtl/rcv_pkg.sv
// rtl/rcv_pkg.sv - shared constants and state type for the receive FIFO controller
package rcv_pkg;

    localparam int DEPTH_DEFAULT = 3;
    localparam int PTR_W_DEFAULT = 2;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        ERROR = 2'd1,
        FLUSH = 2'd2
    } rcv_ctrl_state_t;

endpackage

// File: rtl/rcv_fifo_ctrl_if.sv
// rtl/rcv_fifo_ctrl_if.sv - request/strobe/status bundle of the receive FIFO controller
// master: drives wr_req, rd_req, flush, err_clr; observes strobes, pointers and flags
// slave : the controller side
interface rcv_fifo_ctrl_if #(
    parameter int PTR_W = 2
);
    logic             wr_req;
    logic             rd_req;
    logic             flush;
    logic             err_clr;
    logic             wr_en;
    logic             rd_en;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W-1:0] head_ptr;
    logic             full;
    logic             empty;
    logic [PTR_W:0]   count;
    logic             overflow;

    modport master (
        output wr_req, rd_req, flush, err_clr,
        input  wr_en, rd_en, tail_ptr, head_ptr, full, empty, count, overflow
    );

    modport slave (
        input  wr_req, rd_req, flush, err_clr,
        output wr_en, rd_en, tail_ptr, head_ptr, full, empty, count, overflow
    );
endinterface

// File: rtl/rcv_wrap_ptr.sv
// rtl/rcv_wrap_ptr.sv - wrapping row pointer with lap toggle
// clk, n_rst : clock, synchronous active-low reset
// adv        : step the pointer by one row
// clr        : force pointer and toggle to zero (wins over adv)
// wrap_val   : last legal row index; the step after it returns to 0 and flips tog
// ptr, tog   : current row index and lap parity
module rcv_wrap_ptr #(
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             adv,
    input  logic             clr,
    input  logic [PTR_W-1:0] wrap_val,
    output logic [PTR_W-1:0] ptr,
    output logic             tog
);

    always_ff @(posedge clk) begin
        if (!n_rst || clr) begin
            ptr <= '0;
            tog <= 1'b0;
        end else if (adv) begin
            if (ptr == wrap_val) begin
                ptr <= '0;
                tog <= ~tog;
            end else begin
                ptr <= ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rcv_fifo_ctrl.sv
// rtl/rcv_fifo_ctrl.sv - pointer, flag and flow controller for the receive FIFO
// clk, n_rst : clock, synchronous active-low reset
// bus        : requests in (wr_req, rd_req, flush, err_clr); strobes out (wr_en, rd_en);
//              status out (tail_ptr, head_ptr, full, empty, count, overflow)
module rcv_fifo_ctrl
    import rcv_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int PTR_W = PTR_W_DEFAULT
) (
    input  logic         clk,
    input  logic         n_rst,
    rcv_fifo_ctrl_if.slave bus
);

    rcv_ctrl_state_t  state_q, state_d;
    logic             wr_en, rd_en;
    logic             ptr_clr, ovf_set, ovf_clr;
    logic             tail_tog, head_tog;
    logic [PTR_W-1:0] tail_ptr, head_ptr;
    logic [PTR_W:0]   count_q;
    logic             overflow_q;
    logic             full, empty;

    localparam logic [PTR_W-1:0] WRAP_VAL = PTR_W'(DEPTH - 1);

    rcv_wrap_ptr #(.PTR_W(PTR_W)) u_tail (
        .clk(clk), .n_rst(n_rst), .adv(wr_en), .clr(ptr_clr),
        .wrap_val(WRAP_VAL), .ptr(tail_ptr), .tog(tail_tog)
    );

    rcv_wrap_ptr #(.PTR_W(PTR_W)) u_head (
        .clk(clk), .n_rst(n_rst), .adv(rd_en), .clr(ptr_clr),
        .wrap_val(WRAP_VAL), .ptr(head_ptr), .tog(head_tog)
    );

    // Equal indices are ambiguous on their own; the lap parity tells empty from full.
    assign empty = (head_ptr == tail_ptr) && (head_tog == tail_tog);
    assign full  = (head_ptr == tail_ptr) && (head_tog != tail_tog);

    always_ff @(posedge clk) begin
        if (!n_rst) state_q <= RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        ptr_clr = 1'b0;
        ovf_set = 1'b0;
        ovf_clr = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.flush) begin
                    state_d = FLUSH;
                    ptr_clr = 1'b1;
                end else begin
                    wr_en = bus.wr_req && !full;
                    rd_en = bus.rd_req && !empty;
                    if (bus.wr_req && full) begin
                        state_d = ERROR;
                        ovf_set = 1'b1;
                    end
                end
            end
            ERROR: begin
                // Writes stay blocked, but the consumer may keep draining.
                if (bus.flush) begin
                    state_d = FLUSH;
                    ptr_clr = 1'b1;
                    ovf_clr = 1'b1;
                end else begin
                    rd_en = bus.rd_req && !empty;
                    if (bus.err_clr) begin
                        state_d = RUN;
                        ovf_clr = 1'b1;
                    end
                end
            end
            FLUSH: begin
                // Pointers were cleared on the entry edge; hold them cleared one more cycle.
                state_d = RUN;
                ptr_clr = 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst || ptr_clr) begin
            count_q <= '0;
        end else begin
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst || ovf_clr) overflow_q <= 1'b0;
        else if (ovf_set)      overflow_q <= 1'b1;
    end

    assign bus.wr_en    = wr_en;
    assign bus.rd_en    = rd_en;
    assign bus.tail_ptr = tail_ptr;
    assign bus.head_ptr = head_ptr;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_rcv_fifo_ctrl.sv
// tb/tb_rcv_fifo_ctrl.sv - self-checking bench for rcv_fifo_ctrl
module tb_rcv_fifo_ctrl;
    localparam int DEPTH = 3;
    localparam int PTR_W = 2;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    rcv_fifo_ctrl_if #(.PTR_W(PTR_W)) bus ();

    rcv_fifo_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk),
        .n_rst(n_rst),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference: total rows written/read since the last clear; everything else follows.
    int wr_cnt, rd_cnt;
    bit m_err, m_flushing;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit w, input bit r, input bit f, input bit c, input bit rst_n);
        int  occ;
        bit  m_full, m_empty, exp_wr, exp_rd;
        bus.wr_req  = w;
        bus.rd_req  = r;
        bus.flush   = f;
        bus.err_clr = c;
        n_rst       = rst_n;
        @(negedge clk);
        occ     = wr_cnt - rd_cnt;
        m_full  = (occ == DEPTH);
        m_empty = (occ == 0);
        exp_wr  = !m_flushing && !m_err && !f && w && !m_full;
        exp_rd  = !m_flushing && !f && r && !m_empty;
        chk("tail_ptr", 32'(bus.tail_ptr), 32'(wr_cnt % DEPTH));
        chk("head_ptr", 32'(bus.head_ptr), 32'(rd_cnt % DEPTH));
        chk("tail_tog", 32'(dut.u_tail.tog), 32'((wr_cnt / DEPTH) % 2));
        chk("head_tog", 32'(dut.u_head.tog), 32'((rd_cnt / DEPTH) % 2));
        chk("count", 32'(bus.count), 32'(occ));
        chk("full", 32'(bus.full), 32'(m_full));
        chk("empty", 32'(bus.empty), 32'(m_empty));
        chk("overflow", 32'(bus.overflow), 32'(m_err));
        if (rst_n) begin
            chk("wr_en", 32'(bus.wr_en), 32'(exp_wr));
            chk("rd_en", 32'(bus.rd_en), 32'(exp_rd));
        end
        if (!rst_n) begin
            wr_cnt = 0; rd_cnt = 0; m_err = 0; m_flushing = 0;
        end else if (m_flushing) begin
            m_flushing = 0;
        end else if (f) begin
            wr_cnt = 0; rd_cnt = 0; m_err = 0; m_flushing = 1;
        end else begin
            wr_cnt += int'(exp_wr);
            rd_cnt += int'(exp_rd);
            if (m_err && c)               m_err = 0;
            else if (!m_err && w && m_full) m_err = 1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.wr_req = 0; bus.rd_req = 0; bus.flush = 0; bus.err_clr = 0;
        n_rst = 0;
        wr_cnt = 0; rd_cnt = 0; m_err = 0; m_flushing = 0;
        @(posedge clk);
        #1;
        step(0, 0, 0, 0, 1);

        // Fill to full, then overflow
        repeat (3) step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        // Drain while in ERROR, then clear and write again
        repeat (2) step(0, 1, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 1);
        // Drain fully, then read from empty
        repeat (3) step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        // Simultaneous write/read from empty, then at count=1
        step(1, 1, 0, 0, 1);
        repeat (5) step(1, 1, 0, 0, 1);
        // Fill and simultaneous requests while full
        repeat (2) step(1, 0, 0, 0, 1);
        step(1, 1, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        // Flush from ERROR with err_clr and wr_req
        step(1, 0, 1, 1, 1);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        // count=2 with flush and wr_req together
        step(1, 0, 0, 0, 1);
        step(1, 1, 1, 0, 1);
        step(0, 0, 0, 0, 1);
        // Reset mid-operation with count=2, head_ptr=1
        repeat (3) step(1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
                 $urandom_range(0, 99) < 3,  $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) >= 1);
        end
        step(0, 0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
